// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one external combinational AND unit among
// NREQ requesters; returns each result with its owner ID over a valid/ready port.
module and_unit_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_in,
    input  logic [NREQ*WIDTH-1:0]   b_in,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        unit_a,
    output logic [WIDTH-1:0]        unit_b,
    input  logic [WIDTH-1:0]        unit_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     pend_q, pend_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [WIDTH-1:0]   unit_a_q, unit_a_d;
    logic [WIDTH-1:0]   unit_b_q, unit_b_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;

    logic               found;
    logic [IDW-1:0]     sel;
    logic [IDW-1:0]     sel_next;
    int unsigned        idx;

    // First set request at or above the pointer, wrapping past NREQ-1.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
        sel_next = (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        pend_d      = pend_q;
        gnt_d       = '0;
        unit_a_d    = unit_a_q;
        unit_b_d    = unit_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d[sel] = 1'b1;
                    unit_a_d   = a_in[int'(sel)*WIDTH +: WIDTH];
                    unit_b_d   = b_in[int'(sel)*WIDTH +: WIDTH];
                    pend_d     = sel;
                    ptr_d      = sel_next;
                    state_d    = StExec;
                end
            end
            StExec: begin
                rsp_data_d  = unit_out;
                rsp_id_d    = pend_q;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            pend_q      <= '0;
            gnt_q       <= '0;
            unit_a_q    <= '0;
            unit_b_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            pend_q      <= pend_d;
            gnt_q       <= gnt_d;
            unit_a_q    <= unit_a_d;
            unit_b_q    <= unit_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign gnt       = gnt_q;
    assign unit_a    = unit_a_q;
    assign unit_b    = unit_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Directed bench for and_unit_arbiter; the shared AND unit is modelled here.
module tb_and_unit_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned IDW = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      unit_a;
    logic [WIDTH-1:0]      unit_b;
    logic [WIDTH-1:0]      unit_out;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    and_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .unit_a    (unit_a),
        .unit_b    (unit_b),
        .unit_out  (unit_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    assign unit_out = unit_a & unit_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        a_in      = '0;
        b_in      = '0;
        rsp_ready = 1'b0;

        // Reset: everything zero for 10 cycles with no requests.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            check("reset_outs", {gnt, unit_a, unit_b, rsp_valid, rsp_id, rsp_data, busy}, 32'h0);
            tick();
        end

        // Single request from requester 1.
        req            = 4'b0010;
        a_in[15:8]     = 8'hF0;
        b_in[15:8]     = 8'h3C;
        tick();
        check("single_gnt", gnt, 4'b0010);
        check("single_unit_a", unit_a, 8'hF0);
        check("single_unit_b", unit_b, 8'h3C);
        check("single_busy", busy, 1'b1);
        check("single_novalid", rsp_valid, 1'b0);
        req       = 4'b0000;
        rsp_ready = 1'b1;
        tick();
        check("single_gnt_clr", gnt, 4'b0000);
        check("single_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'd1, 8'h30});
        tick();
        check("single_done", {rsp_valid, busy, rsp_data}, {1'b0, 1'b0, 8'h30});

        // All four held: pointer restarted at 0 by reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_in[i*WIDTH +: WIDTH] = 8'hFF;
            b_in[i*WIDTH +: WIDTH] = 8'(8'h11 * (i + 1));
        end
        req       = 4'b1111;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_gnt", gnt, 32'(1 << i));
            check("rr_unit_b", unit_b, 32'(8'h11 * (i + 1)));
            if (i == 3) req = 4'b0000;
            tick();
            check("rr_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'(i), 8'(8'h11 * (i + 1))});
            tick();
            check("rr_idle", {busy, gnt}, 5'b0);
        end

        // Back-pressure: pointer is 0, only requester 2 asks.
        req           = 4'b0100;
        a_in[23:16]   = 8'h0F;
        b_in[23:16]   = 8'hFF;
        rsp_ready     = 1'b0;
        tick();
        check("bp_gnt", gnt, 4'b0100);
        req = 4'b0000;
        tick();
        check("bp_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'd2, 8'h0F});
        for (int c = 0; c < 5; c++) begin
            req  = 4'(c * 5 + 3);
            a_in = 32'($urandom);
            b_in = 32'($urandom);
            tick();
            check("bp_hold_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'd2, 8'h0F});
            check("bp_hold_unit", {unit_a, unit_b}, 16'h0FFF);
            check("bp_no_gnt", {gnt, busy}, 5'b00001);
        end
        req       = 4'b0000;
        rsp_ready = 1'b1;
        tick();
        check("bp_release", {rsp_valid, busy}, 2'b00);

        // Wrap-around: pointer is 3 after granting requester 2.
        a_in = 32'hAA_55_33_0F;
        b_in = 32'hCC_F0_0F_3C;
        req  = 4'b1000;
        tick();
        check("wrap_gnt3", gnt, 4'b1000);
        req = 4'b1001;
        tick();
        check("wrap_rsp3", {rsp_id, rsp_data}, {2'd3, 8'h88});
        tick();
        tick();
        check("wrap_gnt0", gnt, 4'b0001);
        req = 4'b1010;
        tick();
        check("wrap_rsp0", {rsp_id, rsp_data}, {2'd0, 8'h0C});
        tick();
        tick();
        check("wrap_gnt1", gnt, 4'b0010);
        req       = 4'b0000;
        rsp_ready = 1'b0;
        tick();
        check("mid_rsp_valid", {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'd1, 8'h03});

        // Asynchronous reset while a response is pending.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {rsp_valid, busy, gnt}, 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0101;
        tick();
        check("post_rst_gnt", gnt, 4'b0001);
        req = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
